// File: rtl/uart_tx_pkg.sv
// Shared types, constants and the CRC-16/CCITT-FALSE byte update for the block UART transmitter.
package uart_tx_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic {
        BYTE_IDLE,
        BYTE_SEND
    } byte_state_e;

    typedef enum logic [1:0] {
        BIT_START,
        BIT_DATA,
        BIT_PAR,
        BIT_STOP
    } bit_state_e;

    // Eight MSB-first shift/XOR steps unrolled into one combinational update.
    function automatic logic [15:0] crc16_ccitt_byte(input logic [15:0] crc, input logic [7:0] data_byte);
        logic [15:0] c;
        c = crc ^ {data_byte, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_block_tx_if.sv
// Block handshake plus serial-side status of the block UART transmitter.
interface uart_block_tx_if #(
    parameter int BLOCK_BYTES = 16
);
    logic [8*BLOCK_BYTES-1:0] blk_data;
    logic                     blk_valid;
    logic                     blk_ready;
    logic                     tx_out;
    logic                     busy;
    logic                     frame_done;

    modport master (
        output blk_data, blk_valid,
        input  blk_ready, tx_out, busy, frame_done
    );

    modport slave (
        input  blk_data, blk_valid,
        output blk_ready, tx_out, busy, frame_done
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period clock enable: counts 0..BAUD_DIV-1 and pulses tick on the last count.
module uart_baud_tick #(
    parameter int BAUD_DIV = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

    if (BAUD_DIV < 2) begin : g_bad_div
        $error("uart_baud_tick: BAUD_DIV must be >= 2");
    end

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset || restart || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/uart_block_tx.sv
// Block transmitter: latches one payload, optionally appends CRC-16, and sends it as back-to-back UART frames.
module uart_block_tx
    import uart_tx_pkg::*;
#(
    parameter int BAUD_DIV    = 434,
    parameter int BLOCK_BYTES = 16,
    parameter int CRC_EN      = 1,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic           clk,
    input  logic           reset,
    uart_block_tx_if.slave bus
);
    localparam int IW = $clog2(BLOCK_BYTES + 2);
    localparam logic [IW-1:0] LAST_IDX  = IW'(BLOCK_BYTES - 1 + 2 * CRC_EN);
    localparam logic [IW-1:0] PAY_END   = IW'(BLOCK_BYTES);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    if (BAUD_DIV < 2 || BLOCK_BYTES < 1 || CRC_EN < 0 || CRC_EN > 1 ||
        PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
        $error("uart_block_tx: parameter out of range");
    end

    byte_state_e              state_q, state_d;
    bit_state_e               bit_q, bit_d;
    logic [IW-1:0]            idx_q, idx_d, next_idx;
    logic [15:0]              crc_q, crc_d;
    logic [7:0]               shift_q, shift_d, next_byte, load_byte;
    logic                     par_q, par_d;
    logic [2:0]               bit_cnt_q, bit_cnt_d;
    logic                     stop_q, stop_d;
    logic                     tx_q, tx_d;
    logic                     done_q, done_d;
    logic                     load;
    logic [8*BLOCK_BYTES-1:0] payload_q, pay_sh;
    logic                     accept, tick;

    assign bus.blk_ready  = (state_q == BYTE_IDLE) && !reset;
    assign bus.busy       = (state_q != BYTE_IDLE) && !reset;
    assign bus.tx_out     = tx_q;
    assign bus.frame_done = done_q;
    assign accept         = bus.blk_valid && bus.blk_ready;

    uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clk    (clk),
        .reset  (reset),
        .restart(accept),
        .tick   (tick)
    );

    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        idx_d     = idx_q;
        crc_d     = crc_q;
        shift_d   = shift_q;
        par_d     = par_q;
        bit_cnt_d = bit_cnt_q;
        stop_d    = stop_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        load      = 1'b0;
        next_idx  = idx_q + 1'b1;
        pay_sh    = payload_q << {next_idx, 3'b000};
        // Payload bytes come first; the two CRC bytes follow with the high byte leading.
        if (next_idx < PAY_END) begin
            next_byte = pay_sh[8*BLOCK_BYTES-1 -: 8];
        end else if (next_idx == PAY_END) begin
            next_byte = crc_q[15:8];
        end else begin
            next_byte = crc_q[7:0];
        end
        load_byte = next_byte;

        if (state_q == BYTE_IDLE) begin
            if (accept) begin
                state_d   = BYTE_SEND;
                idx_d     = '0;
                load      = 1'b1;
                load_byte = bus.blk_data[8*BLOCK_BYTES-1 -: 8];
                crc_d     = crc16_ccitt_byte(CRC16_INIT, bus.blk_data[8*BLOCK_BYTES-1 -: 8]);
            end
        end else if (tick) begin
            case (bit_q)
                BIT_START: begin
                    bit_d     = BIT_DATA;
                    bit_cnt_d = 3'd0;
                    tx_d      = shift_q[0];
                end
                BIT_DATA: begin
                    if (bit_cnt_q == 3'd7) begin
                        if (PARITY != PAR_NONE) begin
                            bit_d = BIT_PAR;
                            tx_d  = par_q;
                        end else begin
                            bit_d  = BIT_STOP;
                            stop_d = 1'b0;
                            tx_d   = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
                BIT_PAR: begin
                    bit_d  = BIT_STOP;
                    stop_d = 1'b0;
                    tx_d   = 1'b1;
                end
                default: begin
                    if (stop_q == STOP_LAST) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = BYTE_IDLE;
                            done_d  = 1'b1;
                            tx_d    = 1'b1;
                        end else begin
                            idx_d = next_idx;
                            load  = 1'b1;
                            if (next_idx < PAY_END) begin
                                crc_d = crc16_ccitt_byte(crc_q, next_byte);
                            end
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            endcase
        end

        // Loading a byte always begins its start bit on the next cycle.
        if (load) begin
            shift_d = load_byte;
            par_d   = (PARITY == PAR_ODD) ? ~^load_byte : ^load_byte;
            bit_d   = BIT_START;
            tx_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= BYTE_IDLE;
            bit_q     <= BIT_START;
            idx_q     <= '0;
            crc_q     <= CRC16_INIT;
            bit_cnt_q <= 3'd0;
            stop_q    <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            idx_q     <= idx_d;
            crc_q     <= crc_d;
            bit_cnt_q <= bit_cnt_d;
            stop_q    <= stop_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
        if (accept) begin
            payload_q <= bus.blk_data;
        end
    end
endmodule

// File: tb/tb_uart_block_tx.sv
// Directed bench for uart_block_tx: six parameter sets share one clock, selected one at a time.
module tb_uart_block_tx;
    logic         clk = 1'b0;
    logic         reset;
    logic         tb_valid;
    logic [127:0] tb_data;
    logic [2:0]   sel;
    int           n_checks = 0;
    int           n_pass   = 0;
    logic         samp [0:79999];

    always #5 clk = ~clk;

    uart_block_tx_if #(.BLOCK_BYTES(1))  if_a ();
    uart_block_tx_if #(.BLOCK_BYTES(9))  if_b ();
    uart_block_tx_if #(.BLOCK_BYTES(1))  if_c ();
    uart_block_tx_if #(.BLOCK_BYTES(1))  if_d ();
    uart_block_tx_if #(.BLOCK_BYTES(1))  if_e ();
    uart_block_tx_if #(.BLOCK_BYTES(16)) if_f ();

    assign if_a.blk_valid = tb_valid && (sel == 3'd0);
    assign if_b.blk_valid = tb_valid && (sel == 3'd1);
    assign if_c.blk_valid = tb_valid && (sel == 3'd2);
    assign if_d.blk_valid = tb_valid && (sel == 3'd3);
    assign if_e.blk_valid = tb_valid && (sel == 3'd4);
    assign if_f.blk_valid = tb_valid && (sel == 3'd5);
    assign if_a.blk_data  = tb_data[7:0];
    assign if_b.blk_data  = tb_data[71:0];
    assign if_c.blk_data  = tb_data[7:0];
    assign if_d.blk_data  = tb_data[7:0];
    assign if_e.blk_data  = tb_data[7:0];
    assign if_f.blk_data  = tb_data;

    uart_block_tx #(.BAUD_DIV(4), .BLOCK_BYTES(1), .CRC_EN(0), .PARITY(0), .STOP_BITS(1))
        u_a (.clk(clk), .reset(reset), .bus(if_a));
    uart_block_tx #(.BAUD_DIV(4), .BLOCK_BYTES(9), .CRC_EN(1), .PARITY(0), .STOP_BITS(1))
        u_b (.clk(clk), .reset(reset), .bus(if_b));
    uart_block_tx #(.BAUD_DIV(4), .BLOCK_BYTES(1), .CRC_EN(0), .PARITY(1), .STOP_BITS(1))
        u_c (.clk(clk), .reset(reset), .bus(if_c));
    uart_block_tx #(.BAUD_DIV(4), .BLOCK_BYTES(1), .CRC_EN(0), .PARITY(2), .STOP_BITS(1))
        u_d (.clk(clk), .reset(reset), .bus(if_d));
    uart_block_tx #(.BAUD_DIV(4), .BLOCK_BYTES(1), .CRC_EN(0), .PARITY(1), .STOP_BITS(2))
        u_e (.clk(clk), .reset(reset), .bus(if_e));
    uart_block_tx u_f (.clk(clk), .reset(reset), .bus(if_f));

    logic [7:0] tx_v, busy_v, done_v, rdy_v;
    logic       tx, busy, done, rdy;
    assign tx_v   = {2'b11, if_f.tx_out, if_e.tx_out, if_d.tx_out, if_c.tx_out, if_b.tx_out, if_a.tx_out};
    assign busy_v = {2'b00, if_f.busy, if_e.busy, if_d.busy, if_c.busy, if_b.busy, if_a.busy};
    assign done_v = {2'b00, if_f.frame_done, if_e.frame_done, if_d.frame_done, if_c.frame_done,
                     if_b.frame_done, if_a.frame_done};
    assign rdy_v  = {2'b00, if_f.blk_ready, if_e.blk_ready, if_d.blk_ready, if_c.blk_ready,
                     if_b.blk_ready, if_a.blk_ready};
    assign tx   = tx_v[sel];
    assign busy = busy_v[sel];
    assign done = done_v[sel];
    assign rdy  = rdy_v[sel];

    typedef struct {
        logic [2:0]   sel;
        logic [127:0] data;
        int           nbytes;
        int           crc_en;
        int           par_mode;
        int           stop_bits;
        int           bd;
        logic [15:0]  exp_crc;
        logic         exp_par;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Bit-serial reference, independent of the byte-parallel form.
    function automatic logic [15:0] model_crc(input logic [127:0] d, input int n);
        logic [15:0]  c;
        logic [127:0] t;
        logic         fb;
        c = 16'hFFFF;
        t = d << (8 * (16 - n));
        for (int i = 0; i < 8 * n; i++) begin
            fb = c[15] ^ t[127];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
            t = t << 1;
        end
        return c;
    endfunction

    function automatic logic [7:0] rx_byte(input int base, input int bd);
        logic [7:0] b;
        for (int j = 0; j < 8; j++) b[j] = samp[base + (j + 1) * bd + bd / 2];
        return b;
    endfunction

    task automatic run_block(input int vi);
        vec_t         v;
        int           npar, nbits, fc, nwire, total, base;
        int           bad_busy, bad_done, bad_hold, bad_start, bad_stop, bad_par;
        logic [7:0]   exp_b [0:17];
        logic [127:0] t;
        v     = vecs[vi];
        npar  = (v.par_mode != 0) ? 1 : 0;
        nbits = 10 + npar + v.stop_bits - 1;
        fc    = nbits * v.bd;
        nwire = v.nbytes + 2 * v.crc_en;
        total = nwire * fc;
        for (int k = 0; k < v.nbytes; k++) begin
            t = v.data << (8 * (16 - v.nbytes + k));
            exp_b[k] = t[127:120];
        end
        if (v.crc_en != 0) begin
            exp_b[v.nbytes]     = v.exp_crc[15:8];
            exp_b[v.nbytes + 1] = v.exp_crc[7:0];
        end

        @(negedge clk);
        sel = v.sel; tb_data = v.data; tb_valid = 1'b1;
        #1 check($sformatf("v%0d ready", vi), rdy, 1);
        @(posedge clk);
        #1 tb_valid = 1'b0; tb_data = ~v.data;

        bad_busy = 0; bad_done = 0;
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            samp[c] = tx;
            if (busy !== 1'b1) bad_busy++;
            if (done !== 1'b0) bad_done++;
        end
        @(negedge clk);
        check($sformatf("v%0d frame_done at %0d", vi, total), done, 1);
        check($sformatf("v%0d idle line", vi), tx, 1);
        check($sformatf("v%0d ready after", vi), rdy, 1);
        check($sformatf("v%0d busy cleared", vi), busy, 0);
        check($sformatf("v%0d busy gaps", vi), bad_busy, 0);
        check($sformatf("v%0d early frame_done", vi), bad_done, 0);

        bad_hold = 0; bad_start = 0; bad_stop = 0; bad_par = 0;
        for (int k = 0; k < nwire; k++) begin
            base = k * fc;
            for (int b = 0; b < nbits; b++)
                for (int s = 1; s < v.bd; s++)
                    if (samp[base + b * v.bd + s] !== samp[base + b * v.bd]) bad_hold++;
            if (samp[base + v.bd / 2] !== 1'b0) bad_start++;
            check($sformatf("v%0d byte%0d", vi, k), rx_byte(base, v.bd), exp_b[k]);
            if (npar == 1 && samp[base + 9 * v.bd + v.bd / 2] !== v.exp_par) bad_par++;
            for (int s = 0; s < v.stop_bits; s++)
                if (samp[base + (9 + npar + s) * v.bd + v.bd / 2] !== 1'b1) bad_stop++;
        end
        check($sformatf("v%0d bit width", vi), bad_hold, 0);
        check($sformatf("v%0d start bits", vi), bad_start, 0);
        check($sformatf("v%0d stop bits", vi), bad_stop, 0);
        if (npar == 1) check($sformatf("v%0d parity bits", vi), bad_par, 0);
        @(negedge clk);
        check($sformatf("v%0d frame_done one cycle", vi), done, 0);
    endtask

    initial begin
        int n_done, bad_busy, bad_tx;
        vecs[0] = '{3'd0, 128'h55, 1, 0, 0, 1, 4, 16'h0000, 1'b0};
        vecs[1] = '{3'd2, 128'h07, 1, 0, 1, 1, 4, 16'h0000, 1'b1};
        vecs[2] = '{3'd3, 128'h07, 1, 0, 2, 1, 4, 16'h0000, 1'b0};
        vecs[3] = '{3'd4, 128'h07, 1, 0, 1, 2, 4, 16'h0000, 1'b1};
        vecs[4] = '{3'd1, 128'h313233343536373839, 9, 1, 0, 1, 4, 16'h29B1, 1'b0};
        vecs[5] = '{3'd5, 128'hDEADBEEFCAFEBABE1234567890ABCDEF, 16, 1, 0, 1, 434,
                    model_crc(128'hDEADBEEFCAFEBABE1234567890ABCDEF, 16), 1'b0};

        // Reset with valid asserted: nothing may be accepted.
        reset = 1'b1; tb_valid = 1'b1; sel = 3'd0; tb_data = 128'h55;
        repeat (3) @(negedge clk);
        check("reset ready", rdy, 0);
        check("reset busy", busy, 0);
        check("reset tx", tx, 1);
        check("reset frame_done", done, 0);
        reset = 1'b0; tb_valid = 1'b0;
        @(negedge clk);
        check("post-reset ready", rdy, 1);
        check("post-reset busy", busy, 0);

        for (int i = 0; i < 6; i++) run_block(i);

        // Valid held high: one accept per block, second one in the frame_done cycle.
        @(negedge clk);
        sel = 3'd0; tb_data = 128'h55; tb_valid = 1'b1;
        @(posedge clk);
        n_done = 0; bad_busy = 0;
        for (int c = 0; c <= 82; c++) begin
            @(negedge clk);
            samp[c] = tx;
            if (done) n_done++;
            if (c < 40 && busy !== 1'b1) bad_busy++;
            if (c == 5) tb_data = 128'hA3;
            if (c == 40) begin
                check("b2b frame_done", done, 1);
                check("b2b ready", rdy, 1);
            end
            if (c == 41) begin
                tb_valid = 1'b0;
                check("b2b start bit", tx, 0);
                check("b2b busy", busy, 1);
            end
            if (c == 81) check("b2b second frame_done", done, 1);
            if (c == 82) begin
                check("b2b no third accept", busy, 0);
                check("b2b idle", tx, 1);
            end
        end
        check("b2b done count", n_done, 2);
        check("b2b busy gaps", bad_busy, 0);
        check("b2b first byte", rx_byte(0, 4), 8'h55);
        check("b2b second byte", rx_byte(41, 4), 8'hA3);

        // Reset during data bit 1 of byte 3, then a clean block.
        @(negedge clk);
        sel = 3'd1; tb_data = 128'h313233343536373839; tb_valid = 1'b1;
        @(posedge clk);
        #1 tb_valid = 1'b0;
        for (int c = 0; c <= 130; c++) begin
            @(negedge clk);
            if (c == 130) begin
                check("mid busy", busy, 1);
                check("mid data bit", tx, 0);
                reset = 1'b1;
            end
        end
        @(negedge clk);
        check("abort tx", tx, 1);
        check("abort busy", busy, 0);
        check("abort frame_done", done, 0);
        reset = 1'b0;
        n_done = 0; bad_busy = 0; bad_tx = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done) n_done++;
            if (busy) bad_busy++;
            if (!tx) bad_tx++;
        end
        check("abort no frame_done", n_done, 0);
        check("abort stays idle", bad_busy, 0);
        check("abort line high", bad_tx, 0);
        run_block(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
